// File: rtl/cobalt_pkg.sv
// Shared cobalt definitions for the register status table: default widths and the ROB tag type.
package cobalt_pkg;

  localparam int RST_W_ADDR = 5;
  localparam int RST_W_TAG  = 6;

  typedef logic [RST_W_TAG-1:0] rst_tag_t;

  // Pending-count update selected from the per-entry set/clear events.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_BOTH = 2'b11
  } rst_cnt_op_e;

  function automatic rst_cnt_op_e rst_cnt_op(input logic inc, input logic dec);
    return rst_cnt_op_e'({inc, dec});
  endfunction

endpackage

// File: rtl/rst_entry.sv
// One register status entry: pending flag, producer tag, CDB tag compare and regfile write enable.
module rst_entry
  import cobalt_pkg::*;
#(
  parameter int W_ADDR = RST_W_ADDR,
  parameter int W_TAG  = RST_W_TAG,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_rd_en,
  input  logic [W_ADDR-1:0] i_rdaddr,
  input  logic [W_TAG-1:0]  i_rdtag,
  input  logic              i_cdb_valid,
  input  logic [W_TAG-1:0]  i_cdb_tag,
  output logic              o_pending,
  output logic [W_TAG-1:0]  o_tag,
  output logic              o_wen,
  output logic              o_set,
  output logic              o_clr
);

  localparam logic [W_ADDR-1:0] ADDR     = W_ADDR'(IDX);
  localparam logic              WRITABLE = (IDX != 0);

  logic             r_pending;
  logic [W_TAG-1:0] r_tag;
  logic             w_hit;
  logic             w_wen;

  // Register 0 is hardwired: a dispatch to it never renames the entry.
  assign w_hit = i_rd_en & (i_rdaddr == ADDR) & WRITABLE;
  assign w_wen = i_cdb_valid & r_pending & (r_tag == i_cdb_tag) & ~i_flush & i_reset;

  // Entry state: flush beats dispatch, and a new rename beats completion of the old producer.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_pending <= 1'b0;
      r_tag     <= {W_TAG{1'b0}};
    end else if (i_flush) begin
      r_pending <= 1'b0;
      r_tag     <= {W_TAG{1'b0}};
    end else if (w_hit) begin
      r_pending <= 1'b1;
      r_tag     <= i_rdtag;
    end else if (w_wen) begin
      r_pending <= 1'b0;
      r_tag     <= {W_TAG{1'b0}};
    end else begin
      r_pending <= r_pending;
      r_tag     <= r_tag;
    end
  end

  assign o_pending = r_pending;
  assign o_tag     = r_tag;
  assign o_wen     = w_wen;
  assign o_set     = w_hit & ~r_pending;
  assign o_clr     = w_wen & ~w_hit;

endmodule

// File: rtl/reg_status_table.sv
// Register status (rename) table: tracks which architectural registers await a ROB producer.
// Optional macro RST_CDB_BYPASS_EN lets lookups see a same-cycle CDB completion.
module reg_status_table
  import cobalt_pkg::*;
#(
  parameter int W_ADDR = RST_W_ADDR,
  parameter int W_TAG  = $bits(rst_tag_t)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dispatch_rd_en,
  input  logic [W_ADDR-1:0]     dispatch_rdaddr,
  input  logic [W_TAG-1:0]      dispatch_rdtag,
  input  logic [W_ADDR-1:0]     dispatch_rsaddr,
  input  logic [W_ADDR-1:0]     dispatch_rtaddr,
  input  logic                  cdb_valid,
  input  logic [W_TAG-1:0]      cdb_tag,
  input  logic                  flush,
  output logic                  rst_rspending,
  output logic                  rst_rtpending,
  output logic [W_TAG-1:0]      rst_rstag,
  output logic [W_TAG-1:0]      rst_rttag,
  output logic [(1<<W_ADDR)-1:0] rst_wen_onehot,
  output logic [W_ADDR:0]       rst_pending_cnt
);

  localparam int N_ENTRY = 1 << W_ADDR;

  logic             w_pending [N_ENTRY];
  logic [W_TAG-1:0] w_tag     [N_ENTRY];
  logic [N_ENTRY-1:0] w_wen;
  logic [N_ENTRY-1:0] w_set;
  logic [N_ENTRY-1:0] w_clr;
  logic             w_rs_pend;
  logic             w_rt_pend;
  logic [W_ADDR:0]  r_cnt;

  for (genvar gi = 0; gi < N_ENTRY; gi++) begin : g_entry
    rst_entry #(
      .W_ADDR (W_ADDR),
      .W_TAG  (W_TAG),
      .IDX    (gi)
    ) u_entry (
      .clk         (clk),
      .i_reset     (reset),
      .i_flush     (flush),
      .i_rd_en     (dispatch_rd_en),
      .i_rdaddr    (dispatch_rdaddr),
      .i_rdtag     (dispatch_rdtag),
      .i_cdb_valid (cdb_valid),
      .i_cdb_tag   (cdb_tag),
      .o_pending   (w_pending[gi]),
      .o_tag       (w_tag[gi]),
      .o_wen       (w_wen[gi]),
      .o_set       (w_set[gi]),
      .o_clr       (w_clr[gi])
    );
  end

  assign rst_wen_onehot = w_wen;

  // Source lookups; masked to zero while reset is held.
  always_comb begin
    w_rs_pend     = 1'b0;
    w_rt_pend     = 1'b0;
    rst_rspending = 1'b0;
    rst_rtpending = 1'b0;
    rst_rstag     = {W_TAG{1'b0}};
    rst_rttag     = {W_TAG{1'b0}};
`ifdef RST_CDB_BYPASS_EN
    w_rs_pend = w_pending[dispatch_rsaddr] & ~w_wen[dispatch_rsaddr];
    w_rt_pend = w_pending[dispatch_rtaddr] & ~w_wen[dispatch_rtaddr];
`else
    w_rs_pend = w_pending[dispatch_rsaddr];
    w_rt_pend = w_pending[dispatch_rtaddr];
`endif
    if (reset && w_rs_pend) begin
      rst_rspending = 1'b1;
      rst_rstag     = w_tag[dispatch_rsaddr];
    end else begin
      rst_rspending = 1'b0;
      rst_rstag     = {W_TAG{1'b0}};
    end
    if (reset && w_rt_pend) begin
      rst_rtpending = 1'b1;
      rst_rttag     = w_tag[dispatch_rtaddr];
    end else begin
      rst_rtpending = 1'b0;
      rst_rttag     = {W_TAG{1'b0}};
    end
  end

  // Pending counter; at most one set and one clear can occur per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= {(W_ADDR+1){1'b0}};
    end else if (flush) begin
      r_cnt <= {(W_ADDR+1){1'b0}};
    end else begin
      case (rst_cnt_op(|w_set, |w_clr))
        CNT_INC: r_cnt <= r_cnt + {{W_ADDR{1'b0}}, 1'b1};
        CNT_DEC: r_cnt <= r_cnt - {{W_ADDR{1'b0}}, 1'b1};
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign rst_pending_cnt = r_cnt;

endmodule
